// File: rtl/aurora_6466b_link_watchdog.sv
// Aurora 64B/66B link supervisor: waits for channel_up after core reset, filters
// channel drops, pulses soft_rst on loss/timeout/hard error, gives up after MAX_RETRY.
//
// state     | meaning
// IDLE      | supervision disabled
// WAIT_RST  | waiting for reset_pb to release
// WAIT_UP   | waiting for channel_up, bounded by UP_TIMEOUT
// UP        | link stable
// DOWN_FILT | channel_up dropped, filtering for DOWN_FILTER cycles
// RESET     | soft_rst pulse, SOFT_RST_LEN cycles
// FAIL      | retries exhausted, soft_rst held until clear
module aurora_6466b_link_watchdog #(
  parameter int UP_TIMEOUT   = 65536,
  parameter int DOWN_FILTER  = 64,
  parameter int SOFT_RST_LEN = 16,
  parameter int MAX_RETRY    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  input  logic        reset_pb,
  input  logic        channel_up,
  input  logic        hard_err,
  output logic        soft_rst,
  output logic        link_ok,
  output logic        link_fail,
  output logic [7:0]  retry_cnt,
  output logic [15:0] total_retry,
  output logic [2:0]  state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_RST  = 3'd1;
  localparam logic [2:0] WAIT_UP   = 3'd2;
  localparam logic [2:0] UP        = 3'd3;
  localparam logic [2:0] DOWN_FILT = 3'd4;
  localparam logic [2:0] RESET     = 3'd5;
  localparam logic [2:0] FAIL      = 3'd6;

  // The reset pulse length shares the timer, so it takes part in the sizing too.
  localparam int TMAX0 = (UP_TIMEOUT > DOWN_FILTER) ? UP_TIMEOUT : DOWN_FILTER;
  localparam int TMAX  = (TMAX0 > SOFT_RST_LEN) ? TMAX0 : SOFT_RST_LEN;
  localparam int TW    = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] UP_LAST  = TW'(UP_TIMEOUT - 1);
  localparam logic [TW-1:0] DN_LAST  = TW'(DOWN_FILTER - 1);
  localparam logic [TW-1:0] RST_LAST = TW'(SOFT_RST_LEN - 1);
  localparam logic [7:0]    RETRY_LIM = 8'(MAX_RETRY);

  logic          cu_s1_q, cu_s1_d, cu_s2_q, cu_s2_d;
  logic          he_s1_q, he_s1_d, he_s2_q, he_s2_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    retry_cnt_q, retry_cnt_d;
  logic [15:0]   total_retry_q, total_retry_d;
  logic          soft_rst_q, soft_rst_d;
  logic          link_ok_q, link_ok_d;
  logic          link_fail_q, link_fail_d;

  always_comb begin
    cu_s1_d = channel_up;
    cu_s2_d = cu_s1_q;
    he_s1_d = hard_err;
    he_s2_d = he_s1_q;

    state_d = state_q;
    case (state_q)
      IDLE:      if (enable) state_d = WAIT_RST;
      WAIT_RST:  if (!reset_pb) state_d = WAIT_UP;
      WAIT_UP: begin
        if (cu_s2_q)                 state_d = UP;
        else if (timer_q == UP_LAST) state_d = RESET;
      end
      UP: begin
        if (he_s2_q)       state_d = RESET;
        else if (!cu_s2_q) state_d = DOWN_FILT;
      end
      DOWN_FILT: begin
        if (cu_s2_q)                             state_d = UP;
        else if (he_s2_q || timer_q == DN_LAST)  state_d = RESET;
      end
      RESET: begin
        if (timer_q == RST_LAST) begin
          if (MAX_RETRY != 0 && retry_cnt_q >= RETRY_LIM) state_d = FAIL;
          else                                             state_d = WAIT_RST;
        end
      end
      FAIL:      if (clear) state_d = WAIT_RST;
      default:   state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;

    if (state_d != state_q)
      timer_d = '0;
    else if (state_q == WAIT_UP || state_q == DOWN_FILT || state_q == RESET)
      timer_d = timer_q + 1'b1;
    else
      timer_d = timer_q;

    retry_cnt_d   = retry_cnt_q;
    total_retry_d = total_retry_q;
    if (state_d == RESET && state_q != RESET) begin
      if (retry_cnt_q != 8'hFF)      retry_cnt_d   = retry_cnt_q + 8'd1;
      if (total_retry_q != 16'hFFFF) total_retry_d = total_retry_q + 16'd1;
    end
    if (state_d == UP && state_q != UP) retry_cnt_d = '0;
    if (clear) begin
      retry_cnt_d   = '0;
      total_retry_d = '0;
    end

    // Outputs decoded from the next state so they line up with state_q.
    soft_rst_d  = (state_d == RESET) || (state_d == FAIL);
    link_ok_d   = (state_d == UP) || (state_d == DOWN_FILT);
    link_fail_d = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cu_s1_q       <= 1'b0;
      cu_s2_q       <= 1'b0;
      he_s1_q       <= 1'b0;
      he_s2_q       <= 1'b0;
      state_q       <= IDLE;
      timer_q       <= '0;
      retry_cnt_q   <= '0;
      total_retry_q <= '0;
      soft_rst_q    <= 1'b0;
      link_ok_q     <= 1'b0;
      link_fail_q   <= 1'b0;
    end else begin
      cu_s1_q       <= cu_s1_d;
      cu_s2_q       <= cu_s2_d;
      he_s1_q       <= he_s1_d;
      he_s2_q       <= he_s2_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_cnt_q   <= retry_cnt_d;
      total_retry_q <= total_retry_d;
      soft_rst_q    <= soft_rst_d;
      link_ok_q     <= link_ok_d;
      link_fail_q   <= link_fail_d;
    end
  end

  assign soft_rst    = soft_rst_q;
  assign link_ok     = link_ok_q;
  assign link_fail   = link_fail_q;
  assign retry_cnt   = retry_cnt_q;
  assign total_retry = total_retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_aurora_6466b_link_watchdog.sv
// Directed bench for aurora_6466b_link_watchdog: a vector table for bring-up,
// filtering and hard error, then hand sequences for retries, FAIL, enable and reset.
module tb_aurora_6466b_link_watchdog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, clear = 1'b0, reset_pb = 1'b1;
  logic        channel_up = 1'b0, hard_err = 1'b0;
  logic        soft_rst, link_ok, link_fail;
  logic [7:0]  retry_cnt;
  logic [15:0] total_retry;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  aurora_6466b_link_watchdog #(
    .UP_TIMEOUT(100), .DOWN_FILTER(8), .SOFT_RST_LEN(4), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .reset_pb(reset_pb),
    .channel_up(channel_up), .hard_err(hard_err), .soft_rst(soft_rst),
    .link_ok(link_ok), .link_fail(link_fail), .retry_cnt(retry_cnt),
    .total_retry(total_retry), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       en, clr, pb, cu, he;
    logic [2:0] st;
    logic       sr, ok, lf;
    logic [7:0] rc;
    logic [15:0] tr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic en, input logic clr, input logic pb,
                     input logic cu, input logic he, input logic [2:0] st,
                     input logic sr, input logic ok, input logic lf,
                     input logic [7:0] rc, input logic [15:0] tr);
    vec_t v;
    v.n = n; v.en = en; v.clr = clr; v.pb = pb; v.cu = cu; v.he = he;
    v.st = st; v.sr = sr; v.ok = ok; v.lf = lf; v.rc = rc; v.tr = tr;
    tbl.push_back(v);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int i;
    for (i = 0; i < budget && state != s; i++) step();
    chk(name, int'(state), int'(s));
  endtask

  initial begin
    int rises, width, last_rise, cyc, sr_prev, ok_drop, sr_seen, seen_df, lat;
    int gaps[$];
    int widths[$];

    //   n  en clr pb cu he | st sr ok lf rc tr
    add(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    add(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    add(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    add(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
    add(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
    add(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
    add(4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 8'd1, 16'd1);
    add(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1, 16'd1);
    add(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd1, 16'd1);
    add(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd1);
    add(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd1);
    add(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'd1, 16'd2);
    add(3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 8'd1, 16'd2);
    add(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1, 16'd2);
    add(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd1, 16'd2);
    add(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd2);
    add(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);

    // reset values
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_soft_rst", int'(soft_rst), 0);
    chk("rst_link_ok", int'(link_ok), 0);
    chk("rst_total", int'(total_retry), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        enable = tbl[r].en; clear = tbl[r].clr; reset_pb = tbl[r].pb;
        channel_up = tbl[r].cu; hard_err = tbl[r].he;
        step();
        chk($sformatf("v%0d_%0d_state", r, k), int'(state), int'(tbl[r].st));
        chk($sformatf("v%0d_%0d_soft_rst", r, k), int'(soft_rst), int'(tbl[r].sr));
        chk($sformatf("v%0d_%0d_link_ok", r, k), int'(link_ok), int'(tbl[r].ok));
        chk($sformatf("v%0d_%0d_link_fail", r, k), int'(link_fail), int'(tbl[r].lf));
        chk($sformatf("v%0d_%0d_retry_cnt", r, k), int'(retry_cnt), int'(tbl[r].rc));
        chk($sformatf("v%0d_%0d_total", r, k), int'(total_retry), int'(tbl[r].tr));
      end
    end

    // enable drop, then timeout retries into FAIL
    clear = 1'b0; enable = 1'b0;
    step();
    chk("en_off_state", int'(state), 0);
    chk("en_off_link_ok", int'(link_ok), 0);
    enable = 1'b1; reset_pb = 1'b0; channel_up = 1'b0;
    rises = 0; width = 0; last_rise = 0; sr_prev = 0;
    for (cyc = 0; cyc < 1000 && state != 3'd6; cyc++) begin
      step();
      if (soft_rst && !sr_prev) begin
        if (rises > 0) gaps.push_back(cyc - last_rise);
        rises++; last_rise = cyc; width = 0;
      end
      if (soft_rst) width++;
      if (!soft_rst && sr_prev) widths.push_back(width);
      sr_prev = int'(soft_rst);
    end
    chk("to_fail_state", int'(state), 6);
    chk("to_rises", rises, 3);
    chk("to_gap_count", gaps.size(), 2);
    foreach (gaps[g]) chk($sformatf("to_gap%0d", g), gaps[g], 105);
    foreach (widths[w]) chk($sformatf("to_width%0d", w), widths[w], 4);
    chk("to_link_fail", int'(link_fail), 1);
    chk("to_soft_rst", int'(soft_rst), 1);
    chk("to_retry_cnt", int'(retry_cnt), 3);
    chk("to_total", int'(total_retry), 3);
    repeat (5) step();
    chk("fail_hold", int'(state), 6);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_state", int'(state), 1);
    chk("clr_retry_cnt", int'(retry_cnt), 0);
    chk("clr_total", int'(total_retry), 0);
    chk("clr_link_fail", int'(link_fail), 0);
    chk("clr_soft_rst", int'(soft_rst), 0);

    // 5-cycle glitch is absorbed, 12-cycle drop forces one reset pulse
    channel_up = 1'b1;
    wait_state(3'd3, 10, "gl_up");
    ok_drop = 0; sr_seen = 0;
    for (int i = 0; i < 15; i++) begin
      channel_up = (i < 5) ? 1'b0 : 1'b1;
      step();
      if (!link_ok) ok_drop = 1;
      if (soft_rst) sr_seen = 1;
    end
    chk("gl_link_ok_drop", ok_drop, 0);
    chk("gl_soft_rst_seen", sr_seen, 0);
    chk("gl_state", int'(state), 3);
    width = 0; sr_seen = 0;
    for (int i = 0; i < 30; i++) begin
      channel_up = (i < 12) ? 1'b0 : 1'b1;
      step();
      if (soft_rst) begin
        width++;
        if (!sr_seen) begin
          chk("drop_retry_cnt", int'(retry_cnt), 1);
          chk("drop_total", int'(total_retry), 1);
        end
        sr_seen = 1;
      end
    end
    chk("drop_width", width, 4);
    chk("drop_state", int'(state), 3);
    chk("drop_retry_clr", int'(retry_cnt), 0);

    // hard error in UP goes straight to RESET
    seen_df = 0; lat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      hard_err = (i <= 3) ? 1'b1 : 1'b0;
      step();
      if (state == 3'd4) seen_df = 1;
      if (state == 3'd5) lat = i;
    end
    hard_err = 1'b0;
    chk("he_latency", lat, 3);
    chk("he_no_down_filt", seen_df, 0);
    chk("he_retry_cnt", int'(retry_cnt), 1);
    chk("he_total", int'(total_retry), 2);
    wait_state(3'd3, 20, "he_recover");
    chk("he_up_retry_cnt", int'(retry_cnt), 0);
    chk("he_up_total", int'(total_retry), 2);

    // enable drop during RESET
    channel_up = 1'b0;
    wait_state(3'd5, 50, "en_reset_reach");
    enable = 1'b0;
    step();
    chk("en_reset_state", int'(state), 0);
    chk("en_reset_soft_rst", int'(soft_rst), 0);
    chk("en_reset_retry_kept", int'(retry_cnt), 1);
    chk("en_reset_total_kept", int'(total_retry), 3);

    // async reset while in FAIL
    enable = 1'b1;
    wait_state(3'd6, 1000, "ar_fail_reach");
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_soft_rst", int'(soft_rst), 0);
    chk("ar_link_fail", int'(link_fail), 0);
    chk("ar_link_ok", int'(link_ok), 0);
    chk("ar_retry_cnt", int'(retry_cnt), 0);
    chk("ar_total", int'(total_retry), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_6466b_link_watchdog.md
AURORA_6466B_LINK_WATCHDOG -- requirements
Module: aurora_6466b_link_watchdog

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- UP_TIMEOUT, 65536: clk cycles allowed for channel_up to assert after reset_pb falls.
- DOWN_FILTER, 64: clk cycles channel_up must stay low before link loss is declared.
- SOFT_RST_LEN, 16: soft_rst pulse width in clk cycles; minimum 2.
- MAX_RETRY, 8: consecutive retries allowed before FAIL; 0 = unlimited.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: free-running init clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- enable, in, 1: supervision enable.
- clear, in, 1: one-cycle pulse; clears the FAIL state and the retry counts.
- reset_pb, in, 1: core reset status from the power-on reset stage.
- channel_up, in, 1: Aurora channel up, asynchronous to clk.
- hard_err, in, 1: Aurora hard error, asynchronous to clk.
- soft_rst, out, 1: drives the power-on reset stage soft_rst input.
- link_ok, out, 1: link stable.
- link_fail, out, 1: sticky give-up flag.
- retry_cnt, out, 8: consecutive retries.
- total_retry, out, 16: cumulative retries.
- state, out, 3: FSM state encoding.

Function
REQ-003 channel_up and hard_err SHALL each pass through a 2-flop synchronizer; all FSM decisions use the synchronized copies (2-cycle input latency).
REQ-004 hard_err sources SHALL hold hard_err high at least 3 clk cycles.
REQ-005 The FSM states and encodings SHALL be IDLE=0, WAIT_RST=1, WAIT_UP=2, UP=3, DOWN_FILT=4, RESET=5, FAIL=6.
REQ-006 IDLE SHALL move to WAIT_RST when enable=1.
REQ-007 WAIT_RST SHALL move to WAIT_UP when reset_pb=0, and SHALL clear the timer on that transition.
REQ-008 WAIT_UP SHALL move to UP when channel_up_s=1, or to RESET when the timer reaches UP_TIMEOUT-1; if both are true in the same cycle, UP wins.
REQ-009 UP SHALL move to RESET when hard_err_s=1, else to DOWN_FILT when channel_up_s=0; hard_err has priority over channel loss.
REQ-010 DOWN_FILT SHALL return to UP when channel_up_s=1, or move to RESET when the timer reaches DOWN_FILTER-1 or hard_err_s=1; channel_up_s return wins over timer expiry in the same cycle.
REQ-011 On entry to RESET, retry_cnt (saturating at 255) and total_retry (saturating at 65535) SHALL increment by 1.
REQ-012 RESET SHALL hold for exactly SOFT_RST_LEN cycles, then go to FAIL if MAX_RETRY!=0 and retry_cnt>=MAX_RETRY, else to WAIT_RST.
REQ-013 FAIL SHALL hold until clear=1, then go to WAIT_RST.
REQ-014 soft_rst SHALL be registered and high exactly while the state is RESET or FAIL.
REQ-015 link_ok SHALL be registered and high exactly while the state is UP or DOWN_FILT.
REQ-016 link_fail SHALL be high exactly while the state is FAIL.
REQ-017 retry_cnt SHALL clear to 0 on every entry to UP; total_retry SHALL NOT clear on UP.
REQ-018 clear=1 in any state SHALL zero retry_cnt and total_retry; clear has priority over a same-cycle increment.
REQ-019 enable=0 in any state SHALL force IDLE on the next cycle; soft_rst and link_ok are 0 in IDLE; counters are retained.
REQ-020 A single shared timer SHALL be wide enough for the larger of UP_TIMEOUT and DOWN_FILTER, and SHALL clear on every state change.
REQ-021 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, soft_rst=0, link_ok=0, link_fail=0, retry_cnt=0, total_retry=0, timer=0, and both synchronizers to 0.
REQ-023 Deassertion of rst_n SHALL be synchronous to clk (externally synchronized); rst_n asserted mid-RESET SHALL drop soft_rst immediately.

Verification (UP_TIMEOUT=100, DOWN_FILTER=8, SOFT_RST_LEN=4, MAX_RETRY=3)
REQ-024 Normal bring-up: enable=1, reset_pb falls, channel_up rises 20 cycles later -> state=UP and link_ok=1 within 3 cycles; soft_rst never asserted; retry_cnt=0.
REQ-025 Glitch filter: in UP, drop channel_up for 5 cycles -> state returns to UP, link_ok stays 1, no soft_rst; drop it for 12 cycles -> soft_rst high for exactly 4 cycles, retry_cnt=1, total_retry=1.
REQ-026 Timeout retries: channel_up held low -> soft_rst pulses 3 times at 100-cycle spacing plus reset_pb time, then state=FAIL, link_fail=1, soft_rst held high, retry_cnt=3; clear pulse -> retry_cnt=0, total_retry=0, state=WAIT_RST.
REQ-027 Hard error: in UP, hard_err high for 3 cycles -> RESET entered 2-3 cycles later without passing DOWN_FILT; after recovery, entry to UP sets retry_cnt=0 and total_retry keeps its value.
REQ-028 Enable/reset mid-operation: deassert enable during RESET -> state=IDLE and soft_rst=0 next cycle; assert rst_n during FAIL -> all outputs return to reset values asynchronously.
